i2c_reg_target: RTL
===================

Name: i2c_reg_target

Overview:
- Oversampled I2C target (slave) front end. Converts raw SCL/SDA pins into a byte-wide register-access interface.
- Feeds the peripheral register bank: 4-byte memory, GPIO/PWM control and ui_in readback at pointers 0..6.
- Runs on the fast system clock (25-50 MHz). SCL is never used as a clock.
- Implements 7-bit addressing, an 8-bit register pointer with auto-increment, and write and read bursts.

Parameters:
- DEV_ADDR, 7'h70, 7-bit target address (bus bytes 0xE0 write, 0xE1 read).
- FILT_LEN, 3, consecutive equal synchronized samples needed before a pin level change is accepted (glitch filter).

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; one clock; reset is synchronous and active-low
- scl  input  1  raw SCL pin
- sda_i  input  1  raw SDA pin
- sda_o  output  1  SDA output value; constant 0 (open-drain)
- sda_oe  output  1  1 = pull SDA low
- rw  output  1  0 = current transaction is write, 1 = read
- addr  output  8  register pointer
- wen  output  1  one-cycle write strobe
- wdata  output  8  write data, valid while wen=1
- rdata_used  output  1  one-cycle pulse: rdata captured for transmission
- rdata  input  8  read data for the current addr (combinational from the bank)

Behaviour:
- Reset (rst_n=0 at a clk edge) forces: state IDLE, sda_oe=0, rw=0, addr=0, wen=0, wdata=0, rdata_used=0, synchronizers and filters to 1. This applies mid-transfer as well; the target then waits for a fresh START.
- Input path: 2-flop synchronizer, then FILT_LEN filter, then a previous-value flop. scl_rise, scl_fall and sda edges are single-cycle pulses arriving (2+FILT_LEN+1) clk after the pin change.
- Bus conditions:
  - START: filtered SDA falls while SCL=1. From any state, go to ADDR, bitcnt=0, sda_oe=0 (covers repeated START).
  - STOP: filtered SDA rises while SCL=1. From any state, go to IDLE, sda_oe=0.
- Bit sampling: SDA is sampled on scl_rise, MSB first. sda_oe changes only on scl_fall, except the START/STOP/reset release.
- States:
  - IDLE: wait for START.
  - ADDR: shift in 8 bits. At the 8th scl_rise compare bits[7:1] with DEV_ADDR.
    - Match: rw<=bit0, go to ACK_A.
    - Mismatch, including general call: go to IGNORE. Never drive SDA.
  - ACK_A: next scl_fall sets sda_oe=1; the following scl_fall releases it.
    - rw=0: go to PTR.
    - rw=1: load the tx shift register from rdata, pulse rdata_used, drive MSB (sda_oe=~bit) on that same scl_fall, go to TX.
  - PTR: 8 bits in. At the 8th scl_rise, addr<=byte, go to ACK_P (ACK as above), then WR.
  - WR: 8 bits in. At the 8th scl_rise, wdata<=byte and wen=1 for exactly that cycle; addr increments on the next clk (wrap 0xFF->0x00). Go to ACK_W (ACK as above), then WR.
  - TX: shift out on each scl_fall. After the 8th bit, release SDA on its scl_fall and go to MACK. addr increments on the clk after that release.
  - MACK: sample master ACK at scl_rise.
    - ACK (0): at the next scl_fall, load rdata, pulse rdata_used, drive MSB, go to TX.
    - NACK (1): go to IGNORE.
  - IGNORE: SDA released; wait for START/STOP.
- wen and rdata_used are never high in the same cycle. Each is high at most once per byte.
- A STOP or START received mid-byte discards the partial byte: no wen, no pointer change.
- A write transaction with only the pointer byte (then STOP or repeated START) sets addr only, no wen.

Test Plan:
- Write burst: S, 0xE0, 0x02, 0xA5, 0x3C, P. Expect ACK on all 4 bytes; addr=0x02; wen with wdata=0xA5 at addr 2; wen with wdata=0x3C at addr 3; final addr=0x04; no rdata_used.
- Repeated-start read: S, 0xE0, 0x05, Sr, 0xE1, read 2 bytes (ACK, then NACK), P, with the bank returning 0x11@5 and 0x22@6. Expect rw=1; rdata_used twice; master receives 0x11, 0x22; final addr=0x07; sda_oe=0 after the NACK.
- Wrong address: S, 0x72, 0x00, P. Expect sda_oe=0 throughout; no wen/rdata_used; addr unchanged.
- Pointer wrap: write pointer 0xFF, then data 0x01, 0x02. Expect wen at addr 0xFF, then at addr 0x00; final addr=0x01.
- Glitch and abort: a 1-clk SCL pulse causes no bit shift. A STOP after 4 data bits gives no wen. rst_n low for 1 clk in the middle of a TX byte gives sda_oe=0 on the next clk, state IDLE, addr=0.

Source files
------------

// File: rtl/i2c_reg_target.sv
// Oversampled I2C target front end: filters raw SCL/SDA on the system clock and turns bus
// transactions into byte-wide register writes/reads with an auto-incrementing pointer.
module i2c_reg_target #(
  parameter logic [6:0]  DEV_ADDR = 7'h70,
  parameter int unsigned FILT_LEN = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_oe,
  output logic       rw,
  output logic [7:0] addr,
  output logic       wen,
  output logic [7:0] wdata,
  output logic       rdata_used,
  input  logic [7:0] rdata
);

  localparam int unsigned CntW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  typedef enum logic [3:0] {
    StIdle, StAddr, StAckA, StPtr, StAckP, StWr, StAckW, StTx, StMack, StIgnore
  } state_e;

  // Bit 1 carries SCL, bit 0 carries SDA through the whole input path.
  logic [1:0]      sync1_q, sync2_q, filt_q, prev_q;
  logic [CntW-1:0] cnt_q [2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      filt_q  <= '1;
      prev_q  <= '1;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= {scl, sda_i};
      sync2_q <= sync1_q;
      prev_q  <= filt_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          cnt_q[i] <= '0;
        end else if (32'(cnt_q[i]) >= FILT_LEN - 1) begin
          filt_q[i] <= sync2_q[i];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  logic       sda_f, scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] byte_in;

  assign sda_f    = filt_q[0];
  assign scl_rise = filt_q[1] & ~prev_q[1];
  assign scl_fall = ~filt_q[1] & prev_q[1];
  // SDA edges only count as bus conditions while SCL is steadily high.
  assign start_det = filt_q[1] & prev_q[1] & prev_q[0] & ~filt_q[0];
  assign stop_det  = filt_q[1] & prev_q[1] & ~prev_q[0] & filt_q[0];

  assign sda_o = 1'b0;

  state_e     state_q;
  logic [2:0] bitcnt_q;
  logic [6:0] shreg_q;
  logic [6:0] tx_q;
  logic       ack_q;
  logic       inc_q;

  assign byte_in = {shreg_q, sda_f};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      bitcnt_q   <= '0;
      shreg_q    <= '0;
      tx_q       <= '0;
      ack_q      <= 1'b0;
      inc_q      <= 1'b0;
      sda_oe     <= 1'b0;
      rw         <= 1'b0;
      addr       <= '0;
      wen        <= 1'b0;
      wdata      <= '0;
      rdata_used <= 1'b0;
    end else begin
      wen        <= 1'b0;
      rdata_used <= 1'b0;
      inc_q      <= 1'b0;
      if (inc_q) addr <= addr + 8'd1;

      if (start_det) begin
        state_q  <= StAddr;
        bitcnt_q <= '0;
        sda_oe   <= 1'b0;
        ack_q    <= 1'b0;
      end else if (stop_det) begin
        state_q <= StIdle;
        sda_oe  <= 1'b0;
        ack_q   <= 1'b0;
      end else begin
        unique case (state_q)
          StAddr, StPtr, StWr: begin
            if (scl_rise) begin
              shreg_q  <= byte_in[6:0];
              bitcnt_q <= bitcnt_q + 3'd1;
              if (bitcnt_q == 3'd7) begin
                if (state_q == StAddr) begin
                  if (byte_in[7:1] == DEV_ADDR) begin
                    rw      <= byte_in[0];
                    state_q <= StAckA;
                  end else begin
                    state_q <= StIgnore;
                  end
                end else if (state_q == StPtr) begin
                  addr    <= byte_in;
                  state_q <= StAckP;
                end else begin
                  wdata   <= byte_in;
                  wen     <= 1'b1;
                  inc_q   <= 1'b1;
                  state_q <= StAckW;
                end
              end
            end
          end
          // First falling edge pulls SDA for the ACK, the second one ends the ACK slot.
          StAckA, StAckP, StAckW: begin
            if (scl_fall) begin
              if (!ack_q) begin
                sda_oe <= 1'b1;
                ack_q  <= 1'b1;
              end else begin
                ack_q <= 1'b0;
                if (state_q == StAckA && rw) begin
                  tx_q       <= rdata[6:0];
                  sda_oe     <= ~rdata[7];
                  rdata_used <= 1'b1;
                  bitcnt_q   <= '0;
                  state_q    <= StTx;
                end else begin
                  sda_oe  <= 1'b0;
                  state_q <= (state_q == StAckA) ? StPtr : StWr;
                end
              end
            end
          end
          StTx: begin
            if (scl_fall) begin
              if (bitcnt_q == 3'd7) begin
                sda_oe   <= 1'b0;
                inc_q    <= 1'b1;
                bitcnt_q <= '0;
                state_q  <= StMack;
              end else begin
                sda_oe   <= ~tx_q[6];
                tx_q     <= {tx_q[5:0], 1'b0};
                bitcnt_q <= bitcnt_q + 3'd1;
              end
            end
          end
          StMack: begin
            if (scl_rise) begin
              if (sda_f) state_q <= StIgnore;
              else       ack_q   <= 1'b1;
            end else if (scl_fall && ack_q) begin
              ack_q      <= 1'b0;
              tx_q       <= rdata[6:0];
              sda_oe     <= ~rdata[7];
              rdata_used <= 1'b1;
              bitcnt_q   <= '0;
              state_q    <= StTx;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
